// File: rtl/seq_multiplier_param.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or two's-complement per operation.
// Optional macro MULT_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module seq_multiplier_param #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               finish;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_in;

    // Magnitudes of the most-negative operand still fit in WIDTH unsigned bits.
    always_comb begin
        mag_a  = (signed_mode && a[WIDTH-1]) ? -a : a;
        mag_b  = (signed_mode && b[WIDTH-1]) ? -b : b;
        neg_in = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]) && (a != '0) && (b != '0);
    end

    always_comb begin
`ifdef MULT_EARLY_TERM_EN
        finish = (cnt == CW'(WIDTH)) || ((cnt != '0) && (mplier == '0));
`else
        finish = (cnt == CW'(WIDTH));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)  state_next = RUN;
            RUN:     if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done   <= 1'b0;
            out    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mplier <= mag_b;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= neg_in;
                    end
                end
                RUN: begin
                    if (finish) begin
                        out  <= neg ? -acc : acc;
                        done <= 1'b1;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mplier <= mplier >> 1;
                        mcand  <= mcand << 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Scoreboard bench for seq_multiplier_param (WIDTH=6): stimulus pushes expected product and done cycle,
// a monitor pops and compares on every done pulse.
module tb_seq_multiplier_param;

    localparam int W = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            signed_mode = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  out;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    seq_multiplier_param #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .out         (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors = vectors + 1;
        if (act != req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Cycles from the start edge to the completion edge.
    function automatic int lat(input logic [W-1:0] bv, input logic sm);
        logic [W-1:0] m;
        int n;
        m = (sm && bv[W-1]) ? -bv : bv;
        n = 1;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
`ifdef MULT_EARLY_TERM_EN
        return n + 1;
`else
        return W + 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", int'(out), int'(e.prod));
                check("done_cycle", cyc, e.cyc);
                check("busy_with_done", int'(busy), 0);
            end
        end
    end

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Called at a negedge; the following posedge is the start edge E0.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sm, input logic [2*W-1:0] prod);
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        sb.push_back('{prod, cyc + 1 + lat(bv, sm)});
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv; signed_mode = ~sm;
        wait_drain();
    endtask

    initial begin
        int l1;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_out", int'(out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(6'd2, 6'd2, 1'b0, 12'h004);

        // start held high across two operations
        a = 6'd5; b = 6'd3; signed_mode = 1'b0; start = 1'b1;
        l1 = lat(6'd3, 1'b0);
        sb.push_back('{12'h00F, cyc + 1 + l1});
        sb.push_back('{12'h007, cyc + 1 + l1 + 1 + lat(6'd7, 1'b0)});
        @(negedge clk);
        a = 6'd1; b = 6'd7;
        repeat (l1 + 1) @(negedge clk);
        start = 1'b0;
        wait_drain();

        run_op(6'b110011, 6'b001011, 1'b0, 12'h231);
        run_op(6'b110011, 6'b001011, 1'b1, 12'hF71);
        run_op(6'b100000, 6'b100000, 1'b1, 12'h400);
        run_op(6'b111111, 6'b111111, 1'b1, 12'h001);
        run_op(6'b100000, 6'b011111, 1'b1, 12'hC20);
        run_op(6'b111111, 6'b111111, 1'b0, 12'hF81);
        run_op(6'd0, 6'b111011, 1'b1, 12'h000);
        run_op(6'd7, 6'd1, 1'b0, 12'h007);
        run_op(6'd3, 6'b100000, 1'b0, 12'h060);
        run_op(6'd9, 6'd0, 1'b0, 12'h000);

        // start pulsed at E3 of a running operation is ignored
        a = 6'd2; b = 6'b100101; signed_mode = 1'b0; start = 1'b1;
        sb.push_back('{12'h04A, cyc + 1 + lat(6'b100101, 1'b0)});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 6'd7; b = 6'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", int'(busy), 1);
        wait_drain();
        check("out_holds", int'(out), 12'h04A);

        // reset at E3 aborts the operation
        a = 6'd3; b = 6'b100101; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_out", int'(out), 0);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
